// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types, serial frame constants and CRC4 helper
//
// Purpose: definitions shared by the ALU serial blocks.
//   alu_op_t      : supported ALU opcodes
//   pkt_type_e    : serial packet type (DATA / CTL)
//   packet_t      : one received packet (type + payload byte)
//   ERR_*_BIT     : bit positions inside err_flags
//   DATA_PKT_NUM  : DATA packets per command frame
//   get_crc4_d68  : CRC4 (x^4+x+1, init 0) over a 68-bit vector, MSB first
//   is_valid_op   : true for opcodes the ALU core implements
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } alu_op_t;

  typedef enum logic {
    PKT_DATA = 1'b0,
    PKT_CTL  = 1'b1
  } pkt_type_e;

  typedef struct packed {
    pkt_type_e  ptype;
    logic [7:0] data;
  } packet_t;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  localparam int DATA_PKT_NUM = 8;

  // Bit-serial LFSR form: feedback is the outgoing MSB xor the incoming bit,
  // and the x^1 + x^0 taps of the polynomial are folded in on feedback.
  function automatic logic [3:0] get_crc4_d68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0};
      if (fb) begin
        c = c ^ 4'b0011;
      end
    end
    return c;
  endfunction

  function automatic logic is_valid_op(input logic [2:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_serial_rx_packet.sv
// rtl/alu_serial_rx_packet.sv - bit-level receiver for one 11-bit serial packet
//
// Purpose: walks start / type / 8 data bits (MSB first) / stop on the sin
// line and reports each completed packet for one cycle.
// Ports:
//   clk           in   system clock, sin sampled on posedge
//   rst_n         in   asynchronous active-low reset
//   sin           in   serial input, idles high
//   pkt_valid     out  one-cycle pulse, packet completed
//   pkt_type      out  0 = DATA, 1 = CTL (valid with pkt_valid)
//   pkt_data      out  payload byte (valid with pkt_valid)
//   pkt_frame_err out  stop bit was sampled as 0 (valid with pkt_valid)
//   pkt_idle      out  FSM is waiting for a start bit
module alu_serial_rx_packet
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       pkt_valid,
  output logic       pkt_type,
  output logic [7:0] pkt_data,
  output logic       pkt_frame_err,
  output logic       pkt_idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_BITS,
    S_STOP
  } pkt_state_e;

  pkt_state_e state_q;
  logic [2:0] bit_cnt_q;
  packet_t    pkt_q;
  logic       valid_q;
  logic       frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      pkt_q       <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!sin) begin
            state_q <= S_TYPE;
          end
        end
        S_TYPE: begin
          pkt_q.ptype <= pkt_type_e'(sin);
          bit_cnt_q   <= 3'd7;
          state_q     <= S_BITS;
        end
        S_BITS: begin
          pkt_q.data <= {pkt_q.data[6:0], sin};
          if (bit_cnt_q == 3'd0) begin
            state_q <= S_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q - 3'd1;
          end
        end
        S_STOP: begin
          // Return straight to IDLE so a start bit on the very next clock is
          // accepted (back-to-back packets).
          valid_q     <= 1'b1;
          frame_err_q <= ~sin;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pkt_valid     = valid_q;
  assign pkt_type      = pkt_q.ptype;
  assign pkt_data      = pkt_q.data;
  assign pkt_frame_err = frame_err_q;
  assign pkt_idle      = (state_q == S_IDLE);

endmodule

// File: rtl/alu_serial_rx.sv
// rtl/alu_serial_rx.sv - serial command-frame deserializer and checker for the ALU
//
// Purpose: assembles 8 DATA packets (B then A, MSB byte first) and one CTL
// packet into a command, checks data count, CRC4 and opcode, and issues a
// one-cycle out_valid or a classified one-cycle err_valid.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   sin       in   serial input, idles high
//   a         out  operand A, updated only on out_valid
//   b         out  operand B, updated only on out_valid
//   op        out  opcode (CTL bits [6:4]), updated only on out_valid
//   out_valid out  one-cycle pulse, good frame
//   err_valid out  one-cycle pulse, bad frame
//   err_flags out  {ERR_DATA, ERR_CRC, ERR_OP}, valid with err_valid
module alu_serial_rx
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        out_valid,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  logic       pkt_valid;
  logic       pkt_type;
  logic [7:0] pkt_data;
  logic       pkt_frame_err;
  logic       pkt_idle;

  alu_serial_rx_packet u_packet (
    .clk           (clk),
    .rst_n         (rst_n),
    .sin           (sin),
    .pkt_valid     (pkt_valid),
    .pkt_type      (pkt_type),
    .pkt_data      (pkt_data),
    .pkt_frame_err (pkt_frame_err),
    .pkt_idle      (pkt_idle)
  );

  localparam logic [3:0] FULL_CNT = 4'(DATA_PKT_NUM);

  // data_q shifts in bytes so that after 8 DATA packets it holds {B, A}.
  logic [63:0] data_q,      data_d;
  logic [3:0]  count_q,     count_d;
  logic [31:0] idle_cnt_q,  idle_cnt_d;
  logic [31:0] a_q,         a_d;
  logic [31:0] b_q,         b_d;
  logic [2:0]  op_q,        op_d;
  logic        out_valid_q, out_valid_d;
  logic        err_valid_q, err_valid_d;
  logic [2:0]  err_flags_q, err_flags_d;

  logic [2:0]  ctl_op;
  logic [3:0]  crc_calc;

  assign ctl_op   = pkt_data[6:4];
  assign crc_calc = get_crc4_d68({data_q, 1'b1, ctl_op});

  always_comb begin
    data_d      = data_q;
    count_d     = count_q;
    idle_cnt_d  = 32'd0;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    out_valid_d = 1'b0;
    err_valid_d = 1'b0;
    err_flags_d = err_flags_q;

    if (pkt_valid) begin
      if (pkt_frame_err) begin
        err_valid_d               = 1'b1;
        err_flags_d               = 3'b000;
        err_flags_d[ERR_DATA_BIT] = 1'b1;
        count_d                   = 4'd0;
      end else if (pkt_type == PKT_DATA) begin
        if (count_q == FULL_CNT) begin
          // A ninth DATA packet kills the frame immediately.
          err_valid_d               = 1'b1;
          err_flags_d               = 3'b000;
          err_flags_d[ERR_DATA_BIT] = 1'b1;
          count_d                   = 4'd0;
        end else begin
          data_d  = {data_q[55:0], pkt_data};
          count_d = count_q + 4'd1;
        end
      end else begin
        // CTL packet closes the frame; checks are prioritised DATA > CRC > OP.
        count_d     = 4'd0;
        err_flags_d = 3'b000;
        if (count_q != FULL_CNT) begin
          err_valid_d               = 1'b1;
          err_flags_d[ERR_DATA_BIT] = 1'b1;
        end else if (crc_calc != pkt_data[3:0]) begin
          err_valid_d              = 1'b1;
          err_flags_d[ERR_CRC_BIT] = 1'b1;
        end else if (!is_valid_op(ctl_op)) begin
          err_valid_d             = 1'b1;
          err_flags_d[ERR_OP_BIT] = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          b_d         = data_q[63:32];
          a_d         = data_q[31:0];
          op_d        = ctl_op;
        end
      end
    end else if ((TIMEOUT_CYCLES > 0) && (count_q != 4'd0) && pkt_idle && sin) begin
      // Only unbroken runs of idle line mid-frame count toward the timeout.
      if (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
        count_d = 4'd0;
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= 64'd0;
      count_q     <= 4'd0;
      idle_cnt_q  <= 32'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      op_q        <= 3'd0;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_flags_q <= 3'd0;
    end else begin
      data_q      <= data_d;
      count_q     <= count_d;
      idle_cnt_q  <= idle_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      err_valid_q <= err_valid_d;
      err_flags_q <= err_flags_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign out_valid = out_valid_q;
  assign err_valid = err_valid_q;
  assign err_flags = err_flags_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// tb/tb_alu_serial_rx.sv - directed self-checking bench for alu_serial_rx
module tb_alu_serial_rx;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        err_valid;
  logic [2:0]  err_flags;

  int tests;
  int fails;
  int cyc;
  int ok_cnt;
  int err_cnt;
  int ok_cyc[$];
  logic [31:0] ok_a[$];
  logic [31:0] ok_b[$];
  logic [2:0]  ok_op[$];

  alu_serial_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .err_valid (err_valid),
    .err_flags (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      ok_cnt = ok_cnt + 1;
      ok_cyc.push_back(cyc);
      ok_a.push_back(a);
      ok_b.push_back(b);
      ok_op.push_back(op);
    end
    if (err_valid === 1'b1) begin
      err_cnt = err_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of m * x^4 divided by x^4+x+1 (plain polynomial long division).
  function automatic logic [3:0] ref_crc(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) begin
        r[i -: 5] = r[i -: 5] ^ 5'b10011;
      end
    end
    return r[3:0];
  endfunction

  task automatic send_bit(input logic v);
    sin = v;
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i]);
    end
    send_bit(stop);
    sin = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] opv,
                            input int ndata, input logic [3:0] crc_x);
    logic [63:0] ba;
    logic [3:0]  crc;
    ba  = {bv, av};
    crc = ref_crc({bv, av, 1'b1, opv}) ^ crc_x;
    for (int i = 0; i < ndata; i++) begin
      send_pkt(1'b0, ba[63 - 8*i -: 8], 1'b1);
    end
    send_pkt(1'b1, {1'b0, opv, crc}, 1'b1);
  endtask

  int ok0;
  int err0;
  int n0;

  initial begin
    tests   = 0;
    fails   = 0;
    cyc     = 0;
    ok_cnt  = 0;
    err_cnt = 0;
    sin     = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_op", op, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_flags", err_flags, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame A=3, B=5, ADD
    send_frame(32'h3, 32'h5, 3'b100, 8, 4'h0);
    chk("f1_pre_latency", out_valid, 0);
    @(negedge clk);
    chk("f1_out_valid", out_valid, 1);
    chk("f1_err_valid", err_valid, 0);
    chk("f1_a", a, 32'h3);
    chk("f1_b", b, 32'h5);
    chk("f1_op", op, 3'b100);
    @(negedge clk);
    chk("f1_pulse_width", out_valid, 0);
    repeat (2) @(negedge clk);

    // Only 7 DATA packets
    send_frame(32'h1, 32'h2, 3'b001, 7, 4'h0);
    @(negedge clk);
    chk("short_err_valid", err_valid, 1);
    chk("short_err_flags", err_flags, 3'b100);
    chk("short_out_valid", out_valid, 0);
    @(negedge clk);
    chk("short_pulse_width", err_valid, 0);
    repeat (2) @(negedge clk);

    // Bad CRC
    send_frame(32'h3, 32'h5, 3'b100, 8, 4'h1);
    @(negedge clk);
    chk("crc_err_valid", err_valid, 1);
    chk("crc_err_flags", err_flags, 3'b010);
    chk("crc_out_valid", out_valid, 0);
    chk("crc_a_held", a, 32'h3);
    chk("crc_b_held", b, 32'h5);
    chk("crc_op_held", op, 3'b100);
    repeat (2) @(negedge clk);

    // Illegal opcode with correct CRC
    send_frame(32'h7, 32'h9, 3'b111, 8, 4'h0);
    @(negedge clk);
    chk("op_err_valid", err_valid, 1);
    chk("op_err_flags", err_flags, 3'b001);
    chk("op_a_held", a, 32'h3);
    repeat (2) @(negedge clk);

    // Ninth DATA packet -> immediate ERR_DATA
    for (int i = 0; i < 9; i++) begin
      send_pkt(1'b0, 8'(i + 1), 1'b1);
    end
    @(negedge clk);
    chk("ninth_err_valid", err_valid, 1);
    chk("ninth_err_flags", err_flags, 3'b100);
    repeat (2) @(negedge clk);

    // Stop bit sampled as 0
    send_pkt(1'b0, 8'hA5, 1'b0);
    @(negedge clk);
    chk("stop_err_valid", err_valid, 1);
    chk("stop_err_flags", err_flags, 3'b100);
    repeat (3) @(negedge clk);

    // Reset after 4 DATA packets, then a full good frame
    ok0  = ok_cnt;
    err0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      send_pkt(1'b0, 8'h55, 1'b1);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_a_cleared", a, 0);
    send_frame(32'hFFFF_FFFF, 32'h1, 3'b100, 8, 4'h0);
    repeat (3) @(negedge clk);
    chk("midrst_ok_pulses", ok_cnt - ok0, 1);
    chk("midrst_err_pulses", err_cnt - err0, 0);
    chk("midrst_a", a, 32'hFFFF_FFFF);
    chk("midrst_b", b, 32'h1);
    chk("midrst_op", op, 3'b100);

    // Two good frames back-to-back
    n0 = ok_cyc.size();
    send_frame(32'hF0F0_1234, 32'h0FF0_0001, 3'b000, 8, 4'h0);
    send_frame(32'd10, 32'd4, 3'b101, 8, 4'h0);
    repeat (3) @(negedge clk);
    chk("b2b_pulse_count", ok_cyc.size() - n0, 2);
    if (ok_cyc.size() >= n0 + 2) begin
      chk("b2b_spacing", ok_cyc[n0 + 1] - ok_cyc[n0], 99);
      chk("b2b_a0", ok_a[n0], 32'hF0F0_1234);
      chk("b2b_b0", ok_b[n0], 32'h0FF0_0001);
      chk("b2b_op0", ok_op[n0], 3'b000);
      chk("b2b_a1", ok_a[n0 + 1], 32'd10);
      chk("b2b_b1", ok_b[n0 + 1], 32'd4);
      chk("b2b_op1", ok_op[n0 + 1], 3'b101);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
